// File: rtl/prio_encode_pipe_if.sv
// rtl/prio_encode_pipe_if.sv - handshake and result bundle for the pipelined priority encoder
interface prio_encode_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic               out_zero;
    logic               out_multi;
    logic               out_parity;
    logic [CNT_W-1:0]   enc_count;

    // Source of vectors / sink of encoded words
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_zero, out_multi, out_parity, enc_count
    );

    // The encoder itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_zero, out_multi, out_parity, enc_count
    );
endinterface

// File: rtl/prio_encode_pipe.sv
// rtl/prio_encode_pipe.sv - registered priority encoder with parity, flags, handshake and saturating word count
module prio_encode_pipe #(
    parameter int WIDTH      = 16,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit ODD_PARITY = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    prio_encode_pipe_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    logic               r_out_valid;
    logic [IDX_W-1:0]   r_idx;
    logic               r_zero;
    logic               r_multi;
    logic               r_parity;
    logic [CNT_W-1:0]   r_count;

    logic               w_in_ready;
    logic               w_accept;
    logic [IDX_W-1:0]   w_idx;
    logic               w_seen;
    logic               w_multi;
    logic               w_zero;
    logic               w_parity;

    // A single output stage: room exists when empty or when the held word leaves this cycle
    assign w_in_ready = !r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Scan from the winning end; the first set bit found is the index, any later set bit marks multi-hot.
    // The index only ever takes values of real bit positions, so it stays below WIDTH for any WIDTH.
    always_comb begin
        w_idx   = '0;
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.in_data[MSB_FIRST ? (WIDTH - 1 - i) : i]) begin
                if (!w_seen) begin
                    w_idx = IDX_W'(MSB_FIRST ? (WIDTH - 1 - i) : i);
                end else begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
        w_zero   = !w_seen;
        w_parity = (^bus.in_data) ^ ODD_PARITY;
    end

    // Output register: load on accept, drop valid on hand-off without refill, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_zero      <= 1'b0;
            r_multi     <= 1'b0;
            r_parity    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_idx       <= w_idx;
            r_zero      <= w_zero;
            r_multi     <= w_multi;
            r_parity    <= w_parity;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accepted-word counter: clear has priority, then saturating increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_idx    = r_idx;
    assign bus.out_zero   = r_zero;
    assign bus.out_multi  = r_multi;
    assign bus.out_parity = r_parity;
    assign bus.enc_count  = r_count;
endmodule

// File: tb/tb_prio_encode_pipe.sv
// tb/tb_prio_encode_pipe.sv - directed and random checks of the pipelined priority encoder
module tb_prio_encode_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    // a: MSB-first even parity, b: LSB-first, c: odd parity, d: WIDTH=5
    prio_encode_pipe_if #(.WIDTH(4), .CNT_W(2)) a_if ();
    prio_encode_pipe_if #(.WIDTH(4), .CNT_W(2)) b_if ();
    prio_encode_pipe_if #(.WIDTH(4), .CNT_W(2)) c_if ();
    prio_encode_pipe_if #(.WIDTH(5), .CNT_W(8)) d_if ();

    assign b_if.in_valid  = a_if.in_valid;
    assign b_if.in_data   = a_if.in_data;
    assign b_if.out_ready = a_if.out_ready;
    assign c_if.in_valid  = a_if.in_valid;
    assign c_if.in_data   = a_if.in_data;
    assign c_if.out_ready = a_if.out_ready;

    prio_encode_pipe #(.WIDTH(4), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0), .CNT_W(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(a_if));
    prio_encode_pipe #(.WIDTH(4), .MSB_FIRST(1'b0), .ODD_PARITY(1'b0), .CNT_W(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(b_if));
    prio_encode_pipe #(.WIDTH(4), .MSB_FIRST(1'b1), .ODD_PARITY(1'b1), .CNT_W(2)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(c_if));
    prio_encode_pipe #(.WIDTH(5), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0), .CNT_W(8)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(d_if));

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for the 5-bit instance: {idx[2:0], zero, multi, parity}
    function automatic logic [5:0] ref5(input logic [4:0] d);
        logic [2:0] idx;
        int         ones;
        bit         found;
        idx   = 3'd0;
        ones  = 0;
        found = 0;
        for (int i = 4; i >= 0; i--) begin
            if (d[i]) begin
                ones++;
                if (!found) begin
                    idx   = 3'(i);
                    found = 1;
                end
            end
        end
        return {idx, (ones == 0), (ones >= 2), ones[0]};
    endfunction

    task automatic test_reset();
        a_if.in_valid = 1'b0; a_if.in_data = 4'b0; a_if.out_ready = 1'b1;
        d_if.in_valid = 1'b0; d_if.in_data = 5'b0; d_if.out_ready = 1'b1;
        rst_n = 1'b0;
        clr   = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity, a_if.enc_count} !== 8'b0)
            $display("FAIL reset_a: got %b want %b",
                {a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity, a_if.enc_count}, 8'b0);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (a_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_if.in_ready);
        else n_pass++;
    endtask

    task automatic test_encode();
        a_if.in_valid = 1'b1; a_if.out_ready = 1'b1; a_if.in_data = 4'b0100;
        tick();
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity} !== {1'b1, 2'd2, 1'b0, 1'b0, 1'b1})
            $display("FAIL enc_0100: got %b want %b",
                {a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity}, 6'b110001);
        else n_pass++;
        a_if.in_data = 4'b1011;
        tick();
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity} !== {1'b1, 2'd3, 1'b0, 1'b1, 1'b1})
            $display("FAIL enc_1011_msb: got %b want %b",
                {a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity}, 6'b111011);
        else n_pass++;
        n_checks++;
        if (b_if.out_idx !== 2'd0) $display("FAIL enc_1011_lsb_idx: got %0d want 0", b_if.out_idx);
        else n_pass++;
        n_checks++;
        if (c_if.out_parity !== 1'b0) $display("FAIL enc_1011_odd_par: got %b want 0", c_if.out_parity);
        else n_pass++;
        a_if.in_data = 4'b0000;
        tick();
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity} !== {1'b1, 2'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL enc_zero: got %b want %b",
                {a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity}, 6'b100100);
        else n_pass++;
        n_checks++;
        if (c_if.out_parity !== 1'b1) $display("FAIL enc_zero_odd_par: got %b want 1", c_if.out_parity);
        else n_pass++;
        n_checks++;
        if (a_if.enc_count !== 2'd3) $display("FAIL enc_count3: got %0d want 3", a_if.enc_count);
        else n_pass++;
        a_if.in_valid = 1'b0;
        tick();
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.out_zero} !== {1'b0, 2'd0, 1'b1})
            $display("FAIL drain_hold: got %b want %b", {a_if.out_valid, a_if.out_idx, a_if.out_zero}, 4'b0001);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_data = 4'b0010; a_if.out_ready = 1'b0;
        tick();
        a_if.in_data = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (a_if.in_ready !== 1'b0) $display("FAIL stall_in_ready_%0d: got %b want 0", k, a_if.in_ready);
            else n_pass++;
            tick();
            n_checks++;
            if ({a_if.out_valid, a_if.out_idx, a_if.out_multi, a_if.out_parity, a_if.enc_count} !== {1'b1, 2'd1, 1'b0, 1'b1, 2'd1})
                $display("FAIL stall_hold_%0d: got %b want %b", k,
                    {a_if.out_valid, a_if.out_idx, a_if.out_multi, a_if.out_parity, a_if.enc_count}, 7'b1010101);
            else n_pass++;
        end
        a_if.out_ready = 1'b1;
        #1;
        n_checks++;
        if (a_if.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", a_if.in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.enc_count} !== {1'b1, 2'd3, 2'd2})
            $display("FAIL release_word2: got %b want %b", {a_if.out_valid, a_if.out_idx, a_if.enc_count}, 5'b11110);
        else n_pass++;
        a_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] data_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
        logic [1:0] idx_v  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        logic [1:0] cnt_v  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clr = 1'b1;
        tick();
        clr = 1'b0;
        a_if.in_valid = 1'b1; a_if.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_if.in_data = data_v[k];
            tick();
            n_checks++;
            if ({a_if.out_valid, a_if.out_idx, a_if.enc_count} !== {1'b1, idx_v[k], cnt_v[k]})
                $display("FAIL b2b_%0d: got %b want %b", k,
                    {a_if.out_valid, a_if.out_idx, a_if.enc_count}, {1'b1, idx_v[k], cnt_v[k]});
            else n_pass++;
        end
        clr = 1'b1;
        a_if.in_data = 4'b0001;
        tick();
        clr = 1'b0;
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.enc_count} !== {1'b1, 2'd0, 2'd0})
            $display("FAIL clr_wins: got %b want %b", {a_if.out_valid, a_if.out_idx, a_if.enc_count}, 5'b10000);
        else n_pass++;
        a_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        a_if.in_valid = 1'b1; a_if.in_data = 4'b0100; a_if.out_ready = 1'b0;
        tick();
        n_checks++;
        if ({a_if.out_valid, a_if.enc_count} !== {1'b1, 2'd1})
            $display("FAIL pre_reset: got %b want %b", {a_if.out_valid, a_if.enc_count}, 3'b101);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.out_parity, a_if.enc_count} !== 6'b0)
            $display("FAIL async_reset: got %b want %b",
                {a_if.out_valid, a_if.out_idx, a_if.out_parity, a_if.enc_count}, 6'b0);
        else n_pass++;
        a_if.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (a_if.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", a_if.in_ready);
        else n_pass++;
        a_if.in_valid = 1'b1; a_if.in_data = 4'b1001; a_if.out_ready = 1'b1;
        tick();
        n_checks++;
        if ({a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity} !== {1'b1, 2'd3, 1'b0, 1'b1, 1'b0})
            $display("FAIL post_reset_word: got %b want %b",
                {a_if.out_valid, a_if.out_idx, a_if.out_zero, a_if.out_multi, a_if.out_parity}, 6'b111010);
        else n_pass++;
        a_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_width5();
        logic [4:0] data_v [3] = '{5'b10000, 5'b00001, 5'b10101};
        logic [5:0] exp_v  [3] = '{{3'd4, 3'b001}, {3'd0, 3'b001}, {3'd4, 3'b011}};
        d_if.in_valid = 1'b1; d_if.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_if.in_data = data_v[k];
            tick();
            n_checks++;
            if ({d_if.out_valid, d_if.out_idx, d_if.out_zero, d_if.out_multi, d_if.out_parity} !== {1'b1, exp_v[k]})
                $display("FAIL w5_%0d: got %b want %b", k,
                    {d_if.out_valid, d_if.out_idx, d_if.out_zero, d_if.out_multi, d_if.out_parity}, {1'b1, exp_v[k]});
            else n_pass++;
        end
        d_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic       m_valid = 1'b0;
        logic [5:0] m_data  = {3'd4, 3'b011};
        logic [7:0] m_cnt   = 8'd0;
        logic       acc;
        int         words = 0;
        int         cyc   = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        while (words < 1000 && cyc < 5000) begin
            d_if.in_valid  = ($urandom_range(0, 3) != 0);
            d_if.in_data   = 5'($urandom);
            d_if.out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = d_if.in_valid && (!m_valid || d_if.out_ready);
            n_checks++;
            if (d_if.in_ready !== (!m_valid || d_if.out_ready))
                $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, d_if.in_ready, (!m_valid || d_if.out_ready));
            else n_pass++;
            if (acc) begin
                m_valid = 1'b1;
                m_data  = ref5(d_if.in_data);
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                words++;
            end else if (d_if.out_ready) begin
                m_valid = 1'b0;
            end
            tick();
            cyc++;
            n_checks++;
            if ({d_if.out_valid, d_if.out_idx, d_if.out_zero, d_if.out_multi, d_if.out_parity, d_if.enc_count} !== {m_valid, m_data, m_cnt})
                $display("FAIL rnd_out c%0d: got %b want %b", cyc,
                    {d_if.out_valid, d_if.out_idx, d_if.out_zero, d_if.out_multi, d_if.out_parity, d_if.enc_count},
                    {m_valid, m_data, m_cnt});
            else n_pass++;
        end
        n_checks++;
        if (words !== 1000) $display("FAIL rnd_budget: got %0d words want 1000", words);
        else n_pass++;
        d_if.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_width5();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
